// File: rtl/mod241_pkg.sv
// Shared constants, types and the input pre-reduction helper for the mod-241 accumulator.
package mod241_pkg;

  localparam int unsigned MOD   = 241;
  localparam int unsigned RES_W = 8;

  typedef logic [RES_W-1:0] residue_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Folds an out-of-range byte (241..255) back into 0..14.
  function automatic residue_t mod241_reduce(input residue_t x);
    residue_t r;
    if (x >= 8'd241) begin
      r = x - 8'd241;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod241_accum_if.sv
// Term-in / product-out handshake bundle for mod241_accum.
interface mod241_accum_if;
  import mod241_pkg::*;

  logic     in_valid;
  logic     in_ready;
  residue_t in_data;
  logic     in_last;
  logic     out_valid;
  logic     out_ready;
  residue_t out_data;
  logic     out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/mod241_add.sv
// Combinational modular add: two residues in 0..240 give a residue in 0..240.
module mod241_add
  import mod241_pkg::*;
(
  input  residue_t a_i,
  input  residue_t b_i,
  output residue_t sum_o
);

  logic [8:0] raw_s;
  logic [8:0] sub_s;

  // One conditional subtract suffices because both operands are already below 241.
  always_comb begin
    raw_s = {1'b0, a_i} + {1'b0, b_i};
    sub_s = raw_s - 9'd241;
    if (raw_s >= 9'd241) begin
      sum_o = sub_s[7:0];
    end else begin
      sum_o = raw_s[7:0];
    end
  end

endmodule

// File: rtl/mod241_accum.sv
// Accumulates residue terms mod 241 per product. Define MOD241_INRANGE_EN to
// pre-reduce input bytes 241..255; otherwise inputs must already be below 241.
module mod241_accum
  import mod241_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic clk,
  input  logic rst,
  mod241_accum_if.slave acc_if
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_TERMS);

  state_e     state_q, state_d;
  residue_t   acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  residue_t   term_s;
  residue_t   add_a_s;
  residue_t   sum_s;
  logic [7:0] cnt_inc_s;
  logic       ready_s;
  logic       in_fire_s;
  logic       out_fire_s;

`ifdef MOD241_INRANGE_EN
  assign term_s = mod241_reduce(acc_if.in_data);
`else
  assign term_s = acc_if.in_data;
`endif

  // The first term of a product is added to zero so it is reduced the same way as later terms.
  assign add_a_s    = (state_q == ACC) ? acc_q : 8'd0;
  assign cnt_inc_s  = cnt_q + 8'd1;
  assign ready_s    = !rst && (state_q != DONE);
  assign in_fire_s  = acc_if.in_valid && ready_s;
  assign out_fire_s = (state_q == DONE) && acc_if.out_ready;

  mod241_add u_add (
    .a_i   (add_a_s),
    .b_i   (term_s),
    .sum_o (sum_s)
  );

  assign acc_if.in_ready  = ready_s;
  assign acc_if.out_valid = (state_q == DONE);
  assign acc_if.out_data  = acc_q;
  assign acc_if.out_ovf   = ovf_q;

  // Next-state, accumulator, term counter and overflow flag.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_fire_s) begin
          acc_d   = sum_s;
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = acc_if.in_last ? DONE : ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (in_fire_s) begin
          acc_d = sum_s;
          cnt_d = cnt_inc_s;
          if (acc_if.in_last) begin
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (cnt_inc_s == MAX_CNT) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      DONE: begin
        if (out_fire_s) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
